// File: rtl/pong_pkg.sv
// Shared playfield geometry and game state type for the Pong engine.
package pong_pkg;

    localparam int unsigned SCREEN_W     = 64;
    localparam int unsigned SCREEN_H     = 32;
    localparam int unsigned PADDLE_H     = 8;
    localparam int unsigned PADDLE_MAX   = 24;
    localparam int unsigned PADDLE_START = 12;
    localparam int unsigned BALL_CX      = 32;
    localparam int unsigned BALL_CY      = 16;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        POINT,
        GAME_OVER
    } state_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: two-stage button synchronisers and a clamped top-row register.
module pong_paddle
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       en_i,
    input  logic       load_i,
    output logic [5:0] y_o
);

    logic [1:0] up_sync_q;
    logic [1:0] down_sync_q;
    logic [5:0] y_q;
    logic [5:0] y_d;
    logic       up_s;
    logic       down_s;

    assign up_s   = up_sync_q[1];
    assign down_s = down_sync_q[1];

    always_comb begin
        y_d = y_q;
        if (load_i) begin
            y_d = 6'(PADDLE_START);
        end else if (en_i) begin
            if (up_s && !down_s && y_q != '0)
                y_d = y_q - 6'd1;
            else if (down_s && !up_s && y_q != 6'(PADDLE_MAX))
                y_d = y_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_sync_q   <= '0;
            down_sync_q <= '0;
            y_q         <= 6'(PADDLE_START);
        end else begin
            up_sync_q   <= {up_sync_q[0], up_i};
            down_sync_q <= {down_sync_q[0], down_i};
            y_q         <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game-state core: frame tick divider, serve/play/point/game-over FSM,
// ball motion with wall and paddle collisions, scoring.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 833333,
    parameter int unsigned BALL_DIV   = 2,
    parameter int unsigned POINT_HOLD = 60,
    parameter int unsigned WIN_SCORE  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_up,
    input  logic       left_down,
    input  logic       right_up,
    input  logic       right_down,
    input  logic       serve,
    output logic [5:0] ball_x,
    output logic [4:0] ball_y,
    output logic [5:0] left_paddle_y,
    output logic [5:0] right_paddle_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       pos_valid
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;

    state_e        state_q;
    logic [TW-1:0] tick_cnt_q;
    logic [3:0]    ball_cnt_q;
    logic [HW-1:0] hold_q;
    logic [5:0]    ball_x_q;
    logic [4:0]    ball_y_q;
    logic          dx_q;
    logic          dy_q;
    logic [3:0]    score_left_q;
    logic [3:0]    score_right_q;
    logic          game_over_q;
    logic          pos_valid_q;
    logic          armed_q;
    logic [1:0]    serve_sync_q;

    logic          tick;
    logic          serve_s;
    logic          paddle_en;
    logic          restart;
    logic [5:0]    ball_x_d;
    logic [4:0]    ball_y_d;
    logic          dx_d;
    logic          dy_d;
    logic          miss_l;
    logic          miss_r;
    logic          hit_l;
    logic          hit_r;
    logic [6:0]    by_w;

    assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign serve_s   = serve_sync_q[1];
    assign paddle_en = tick && (state_q != GAME_OVER);
    assign restart   = tick && (state_q == GAME_OVER) && serve_s;

    pong_paddle u_left (
        .clk    (clk),
        .reset  (reset),
        .up_i   (left_up),
        .down_i (left_down),
        .en_i   (paddle_en),
        .load_i (restart),
        .y_o    (left_paddle_y)
    );

    pong_paddle u_right (
        .clk    (clk),
        .reset  (reset),
        .up_i   (right_up),
        .down_i (right_down),
        .en_i   (paddle_en),
        .load_i (restart),
        .y_o    (right_paddle_y)
    );

    // Candidate ball step; Y and X resolve independently so a corner applies both.
    always_comb begin
        by_w   = {2'b00, ball_y_q};
        hit_l  = (by_w >= {1'b0, left_paddle_y}) &&
                 (by_w <= {1'b0, left_paddle_y} + 7'(PADDLE_H - 1));
        hit_r  = (by_w >= {1'b0, right_paddle_y}) &&
                 (by_w <= {1'b0, right_paddle_y} + 7'(PADDLE_H - 1));
        dy_d   = dy_q;
        dx_d   = dx_q;
        miss_l = 1'b0;
        miss_r = 1'b0;

        if (ball_y_q == '0 && !dy_q) begin
            dy_d     = 1'b1;
            ball_y_d = 5'd1;
        end else if (ball_y_q == 5'(SCREEN_H - 1) && dy_q) begin
            dy_d     = 1'b0;
            ball_y_d = 5'(SCREEN_H - 2);
        end else begin
            ball_y_d = dy_q ? ball_y_q + 5'd1 : ball_y_q - 5'd1;
        end

        if (ball_x_q == 6'd1 && !dx_q) begin
            if (hit_l) begin
                dx_d     = 1'b1;
                ball_x_d = 6'd2;
            end else begin
                miss_l   = 1'b1;
                ball_x_d = '0;
            end
        end else if (ball_x_q == 6'(SCREEN_W - 2) && dx_q) begin
            if (hit_r) begin
                dx_d     = 1'b0;
                ball_x_d = 6'(SCREEN_W - 3);
            end else begin
                miss_r   = 1'b1;
                ball_x_d = 6'(SCREEN_W - 1);
            end
        end else begin
            ball_x_d = dx_q ? ball_x_q + 6'd1 : ball_x_q - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SERVE;
            tick_cnt_q    <= '0;
            ball_cnt_q    <= '0;
            hold_q        <= '0;
            ball_x_q      <= 6'(BALL_CX);
            ball_y_q      <= 5'(BALL_CY);
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            score_left_q  <= '0;
            score_right_q <= '0;
            game_over_q   <= 1'b0;
            pos_valid_q   <= 1'b0;
            armed_q       <= 1'b0;
            serve_sync_q  <= '0;
        end else begin
            serve_sync_q <= {serve_sync_q[0], serve};
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + TW'(1);
            pos_valid_q  <= tick;

            if (tick) begin
                case (state_q)
                    SERVE: begin
                        if (serve_s && armed_q) begin
                            state_q    <= PLAY;
                            ball_cnt_q <= '0;
                        end else if (!serve_s) begin
                            armed_q <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (ball_cnt_q == 4'(BALL_DIV - 1)) begin
                            ball_cnt_q <= '0;
                            ball_x_q   <= ball_x_d;
                            ball_y_q   <= ball_y_d;
                            dx_q       <= dx_d;
                            dy_q       <= dy_d;
                            if (miss_l) begin
                                score_right_q <= sat_inc(score_right_q, 4'(WIN_SCORE));
                                state_q       <= POINT;
                                hold_q        <= '0;
                            end
                            if (miss_r) begin
                                score_left_q <= sat_inc(score_left_q, 4'(WIN_SCORE));
                                state_q      <= POINT;
                                hold_q       <= '0;
                            end
                        end else begin
                            ball_cnt_q <= ball_cnt_q + 4'd1;
                        end
                    end
                    POINT: begin
                        if (hold_q == HW'(POINT_HOLD - 1)) begin
                            hold_q <= '0;
                            if (score_left_q == 4'(WIN_SCORE) || score_right_q == 4'(WIN_SCORE)) begin
                                state_q     <= GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                // Ball parked at column 0 means the right player scored.
                                state_q  <= SERVE;
                                armed_q  <= 1'b0;
                                dx_q     <= (ball_x_q == '0);
                                dy_q     <= 1'b1;
                                ball_x_q <= 6'(BALL_CX);
                                ball_y_q <= 5'(BALL_CY);
                            end
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    GAME_OVER: begin
                        if (serve_s) begin
                            state_q       <= SERVE;
                            armed_q       <= 1'b0;
                            game_over_q   <= 1'b0;
                            score_left_q  <= '0;
                            score_right_q <= '0;
                            dx_q          <= 1'b1;
                            dy_q          <= 1'b1;
                            ball_x_q      <= 6'(BALL_CX);
                            ball_y_q      <= 5'(BALL_CY);
                        end
                    end
                    default: state_q <= SERVE;
                endcase
            end
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign game_over   = game_over_q;
    assign pos_valid   = pos_valid_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Self-checking bench for pong_game_engine against a behavioural game model.
module tb_pong_game_engine;

    localparam int TD = 4;
    localparam int BD = 1;
    localparam int PH = 2;
    localparam int WS = 3;

    localparam int M_SERVE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_POINT = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lu = 1'b0, ld = 1'b0, ru = 1'b0, rd = 1'b0, sv = 1'b0;
    logic [5:0] ball_x;
    logic [4:0] ball_y;
    logic [5:0] lpy, rpy;
    logic [3:0] sl, sr;
    logic       go, pv;

    int checks = 0;
    int errors = 0;
    int cyc;

    int m_bx, m_by, m_dx, m_dy, m_lp, m_rp, m_sl, m_sr, m_st, m_armed, m_bcnt, m_hold;

    pong_game_engine #(
        .TICK_DIV   (TD),
        .BALL_DIV   (BD),
        .POINT_HOLD (PH),
        .WIN_SCORE  (WS)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .left_up        (lu),
        .left_down      (ld),
        .right_up       (ru),
        .right_down     (rd),
        .serve          (sv),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .left_paddle_y  (lpy),
        .right_paddle_y (rpy),
        .score_left     (sl),
        .score_right    (sr),
        .game_over      (go),
        .pos_valid      (pv)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        check("ball_x", int'(ball_x), m_bx);
        check("ball_y", int'(ball_y), m_by);
        check("left_paddle_y", int'(lpy), m_lp);
        check("right_paddle_y", int'(rpy), m_rp);
        check("score_left", int'(sl), m_sl);
        check("score_right", int'(sr), m_sr);
        check("game_over", int'(go), (m_st == M_OVER) ? 1 : 0);
        check("pos_valid", int'(pv), (cyc > 0 && cyc % TD == 0) ? 1 : 0);
    end

    task automatic mreset();
        m_bx = 32; m_by = 16; m_dx = 1; m_dy = 1;
        m_lp = 12; m_rp = 12; m_sl = 0; m_sr = 0;
        m_st = M_SERVE; m_armed = 0; m_bcnt = 0; m_hold = 0;
    endtask

    function automatic int move(input int y, input bit up, input bit dn);
        if (up && !dn) return (y > 0) ? y - 1 : 0;
        if (dn && !up) return (y < 24) ? y + 1 : 24;
        return y;
    endfunction

    task automatic ball_step(input int olp, input int orp);
        int ndy, ny, nx;
        ndy = m_dy;
        if ((m_by == 0 && m_dy < 0) || (m_by == 31 && m_dy > 0)) ndy = -m_dy;
        ny = m_by + ndy;
        if (m_bx == 1 && m_dx < 0) begin
            if (m_by >= olp && m_by <= olp + 7) begin
                nx = 2; m_dx = 1;
            end else begin
                nx = 0; m_sr = (m_sr + 1 > WS) ? WS : m_sr + 1;
                m_st = M_POINT; m_hold = 0;
            end
        end else if (m_bx == 62 && m_dx > 0) begin
            if (m_by >= orp && m_by <= orp + 7) begin
                nx = 61; m_dx = -1;
            end else begin
                nx = 63; m_sl = (m_sl + 1 > WS) ? WS : m_sl + 1;
                m_st = M_POINT; m_hold = 0;
            end
        end else begin
            nx = m_bx + m_dx;
        end
        m_bx = nx; m_by = ny; m_dy = ndy;
    endtask

    task automatic model_tick(input bit a, input bit b, input bit c, input bit d, input bit s);
        int olp, orp;
        olp = m_lp; orp = m_rp;
        if (m_st != M_OVER) begin
            m_lp = move(m_lp, a, b);
            m_rp = move(m_rp, c, d);
        end
        case (m_st)
            M_SERVE: begin
                if (s && m_armed != 0) begin m_st = M_PLAY; m_bcnt = 0; end
                else if (!s) m_armed = 1;
            end
            M_PLAY: begin
                if (m_bcnt == BD - 1) begin m_bcnt = 0; ball_step(olp, orp); end
                else m_bcnt++;
            end
            M_POINT: begin
                m_hold++;
                if (m_hold == PH) begin
                    m_hold = 0;
                    if (m_sl == WS || m_sr == WS) m_st = M_OVER;
                    else begin
                        m_st = M_SERVE; m_armed = 0;
                        m_dx = (m_bx == 0) ? 1 : -1; m_dy = 1;
                        m_bx = 32; m_by = 16;
                    end
                end
            end
            default: begin
                if (s) begin
                    m_sl = 0; m_sr = 0; m_lp = 12; m_rp = 12;
                    m_bx = 32; m_by = 16; m_dx = 1; m_dy = 1;
                    m_st = M_SERVE; m_armed = 0;
                end
            end
        endcase
    endtask

    // Called at a negedge just after a tick edge (or reset release).
    task automatic do_tick(input bit a, input bit b, input bit c, input bit d, input bit s);
        lu = a; ld = b; ru = c; rd = d; sv = s;
        repeat (TD) @(posedge clk);
        model_tick(a, b, c, d, s);
        @(negedge clk);
    endtask

    task automatic tick_n(input int n, input bit a, input bit b, input bit c, input bit d, input bit s);
        for (int i = 0; i < n; i++) do_tick(a, b, c, d, s);
    endtask

    task automatic play_point(input int k);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 1);
        tick_n(15, 0, 0, 0, 0, 0);
        check("lit_step15_x", int'(ball_x), 47);
        check("lit_step15_y", int'(ball_y), 31);
        do_tick(0, 0, 0, 0, 0);
        check("lit_bounce_x", int'(ball_x), 48);
        check("lit_bounce_y", int'(ball_y), 30);
        tick_n(14, 0, 0, 0, 0, 0);
        check("lit_step30_x", int'(ball_x), 62);
        do_tick(0, 0, 0, 0, 0);
        check("lit_rhit_x", int'(ball_x), 61);
        check("lit_rhit_y", int'(ball_y), 15);
        tick_n(15, 0, 0, 0, 0, 0);
        check("lit_step46_x", int'(ball_x), 46);
        check("lit_step46_y", int'(ball_y), 0);
        tick_n(46, 0, 0, 0, 0, 0);
        check("lit_miss_x", int'(ball_x), 0);
        check("lit_miss_score_right", int'(sr), k);
        tick_n(2, 0, 0, 0, 0, 0);
        if (k < WS) check("lit_recentre_x", int'(ball_x), 32);
        else        check("lit_game_over", int'(go), 1);
    endtask

    initial begin
        logic [31:0] r;
        mreset();
        repeat (3) @(negedge clk);
        check("lit_reset_ball_x", int'(ball_x), 32);
        check("lit_reset_ball_y", int'(ball_y), 16);
        check("lit_reset_lp", int'(lpy), 12);
        check("lit_reset_score", int'(sr), 0);
        rst_n = 1'b1;

        tick_n(20, 1, 0, 0, 0, 0);
        check("lit_left_up_clamp", int'(lpy), 0);
        tick_n(30, 0, 1, 0, 0, 0);
        check("lit_left_down_clamp", int'(lpy), 24);
        check("lit_right_untouched", int'(rpy), 12);

        for (int k = 1; k <= WS; k++) play_point(k);

        do_tick(1, 0, 0, 0, 0);
        check("lit_over_frozen_lp", int'(lpy), 24);
        do_tick(0, 0, 0, 0, 1);
        check("lit_restart_score", int'(sr), 0);
        check("lit_restart_lp", int'(lpy), 12);
        check("lit_restart_go", int'(go), 0);
        do_tick(0, 0, 0, 0, 1);
        check("lit_serve_needs_edge", int'(ball_x), 32);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            do_tick(r[0], r[1], r[2], r[3], ($urandom_range(0, 4) == 0));
        end

        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 1);
        tick_n(5, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mreset();
        #1;
        check("lit_midreset_x", int'(ball_x), 32);
        check("lit_midreset_y", int'(ball_y), 16);
        check("lit_midreset_pv", int'(pv), 0);
        check("lit_midreset_go", int'(go), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            do_tick(r[0], r[1], r[2], r[3], ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
